// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, absolute jump and two-byte interrupt vector fetch.
// Define PC_SEQ_PAGE_CROSS_EN to make page-crossing branches take an extra BR_FIX cycle for the high byte.
module pc_sequencer (
    input  logic        CLK,
    input  logic        RES,
    input  logic        n_ready,
    input  logic        inc_req,
    input  logic        br_req,
    input  logic [7:0]  br_off,
    input  logic        jmp_req,
    input  logic [15:0] jmp_addr,
    input  logic        vec_req,
    input  logic [1:0]  vec_sel,
    input  logic [7:0]  data_in,
    output logic [15:0] PC,
    output logic [15:0] addr,
    output logic        fetch,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BR_FIX = 2'd1,
        VEC_LO = 2'd2,
        VEC_HI = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] base_q, base_d;
    logic [15:0] sum_q, sum_d;
    logic [15:0] br_sum;
    logic [15:0] vec_base;

    assign br_sum = pc_q + {{8{br_off[7]}}, br_off};

    always_comb begin
        case (vec_sel)
            2'b00:   vec_base = 16'hFFFA;
            2'b01:   vec_base = 16'hFFFC;
            default: vec_base = 16'hFFFE;
        endcase
    end

    // n_ready freezes every register; otherwise RUN serves the highest-priority request only
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        sum_d   = sum_q;
        if (!n_ready) begin
            case (state_q)
                RUN: begin
                    if (vec_req) begin
                        base_d  = vec_base;
                        state_d = VEC_LO;
                    end else if (jmp_req) begin
                        pc_d = jmp_addr;
                    end else if (br_req) begin
                        sum_d = br_sum;
`ifdef PC_SEQ_PAGE_CROSS_EN
                        if (br_sum[15:8] != pc_q[15:8]) begin
                            pc_d    = {pc_q[15:8], br_sum[7:0]};
                            state_d = BR_FIX;
                        end else begin
                            pc_d = br_sum;
                        end
`else
                        pc_d = br_sum;
`endif
                    end else if (inc_req) begin
                        pc_d = pc_q + 16'd1;
                    end
                end
                BR_FIX: begin
                    pc_d    = {sum_q[15:8], pc_q[7:0]};
                    state_d = RUN;
                end
                VEC_LO: begin
                    pc_d    = {pc_q[15:8], data_in};
                    state_d = VEC_HI;
                end
                VEC_HI: begin
                    pc_d    = {data_in, pc_q[7:0]};
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= VEC_LO;
            pc_q    <= 16'h0000;
            base_q  <= 16'hFFFC;
            sum_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            sum_q   <= sum_d;
        end
    end

    // Legal vector bases are even, so base+1 never carries out of 16 bits
    always_comb begin
        addr = pc_q;
        case (state_q)
            VEC_LO:  addr = base_q;
            VEC_HI:  addr = base_q + 16'd1;
            default: addr = pc_q;
        endcase
    end

    assign PC    = pc_q;
    assign fetch = (state_q == RUN);
    assign busy  = (state_q != RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: cycle-by-cycle vector table plus hand-written reset-recovery sequences.
// Expected values track PC_SEQ_PAGE_CROSS_EN so the same bench covers both builds.
module tb_pc_sequencer;

    logic        CLK;
    logic        RES;
    logic        n_ready;
    logic        inc_req;
    logic        br_req;
    logic [7:0]  br_off;
    logic        jmp_req;
    logic [15:0] jmp_addr;
    logic        vec_req;
    logic [1:0]  vec_sel;
    logic [7:0]  data_in;
    logic [15:0] PC;
    logic [15:0] addr;
    logic        fetch;
    logic        busy;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct packed {
        logic        res;
        logic        nrdy;
        logic        inc;
        logic        br;
        logic [7:0]  off;
        logic        jmp;
        logic [15:0] jaddr;
        logic        vec;
        logic [1:0]  vsel;
        logic [7:0]  din;
        logic [15:0] exp_pc;
        logic [15:0] exp_addr;
        logic        exp_fetch;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[$];

    pc_sequencer dut (
        .CLK      (CLK),
        .RES      (RES),
        .n_ready  (n_ready),
        .inc_req  (inc_req),
        .br_req   (br_req),
        .br_off   (br_off),
        .jmp_req  (jmp_req),
        .jmp_addr (jmp_addr),
        .vec_req  (vec_req),
        .vec_sel  (vec_sel),
        .data_in  (data_in),
        .PC       (PC),
        .addr     (addr),
        .fetch    (fetch),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic res, input logic nrdy, input logic inc,
                                input logic br, input logic [7:0] off,
                                input logic jmp, input logic [15:0] jaddr,
                                input logic vec, input logic [1:0] vsel, input logic [7:0] din,
                                input logic [15:0] epc, input logic [15:0] eaddr,
                                input logic ef, input logic eb);
        vec_t v;
        v.res = res; v.nrdy = nrdy; v.inc = inc; v.br = br; v.off = off;
        v.jmp = jmp; v.jaddr = jaddr; v.vec = vec; v.vsel = vsel; v.din = din;
        v.exp_pc = epc; v.exp_addr = eaddr; v.exp_fetch = ef; v.exp_busy = eb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        RES      = v.res;
        n_ready  = v.nrdy;
        inc_req  = v.inc;
        br_req   = v.br;
        br_off   = v.off;
        jmp_req  = v.jmp;
        jmp_addr = v.jaddr;
        vec_req  = v.vec;
        vec_sel  = v.vsel;
        data_in  = v.din;
    endtask

    task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkOne({tag, " PC"},    PC,             v.exp_pc);
        checkOne({tag, " addr"},  addr,           v.exp_addr);
        checkOne({tag, " fetch"}, {15'd0, fetch}, {15'd0, v.exp_fetch});
        checkOne({tag, " busy"},  {15'd0, busy},  {15'd0, v.exp_busy});
    endtask

    task automatic stepAndCheck(input vec_t v, input string tag);
        @(negedge CLK);
        applyStimulus(v);
        @(posedge CLK);
        #1;
        checkOutput(v, tag);
    endtask

    initial begin
        applyStimulus(mk(0,0,0,0,8'h00,0,16'h0,0,2'b00,8'h00,16'h0,16'h0,0,0));

        //            res nr inc br off    jmp jaddr     vec sel   din      PC        addr      f  b
        tbl.push_back(mk(1,1,1,1,8'h00,    1,16'h5555,  1,2'b00, 8'h00,  16'h0000, 16'hFFFC, 0, 1));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h34,  16'h0034, 16'hFFFD, 0, 1));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h12,  16'h1234, 16'h1234, 1, 0));
        tbl.push_back(mk(0,0,0,1,8'hFE,    0,16'h0000,  0,2'b00, 8'h00,  16'h1232, 16'h1232, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h1232, 16'h1232, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    1,16'hFFFE,  0,2'b00, 8'h00,  16'hFFFE, 16'hFFFE, 1, 0));
        tbl.push_back(mk(0,0,1,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'hFFFF, 16'hFFFF, 1, 0));
        tbl.push_back(mk(0,0,1,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h0000, 16'h0000, 1, 0));
        tbl.push_back(mk(0,0,1,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h0001, 16'h0001, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    1,16'h10F0,  0,2'b00, 8'h00,  16'h10F0, 16'h10F0, 1, 0));
`ifdef PC_SEQ_PAGE_CROSS_EN
        tbl.push_back(mk(0,0,0,1,8'h20,    0,16'h0000,  0,2'b00, 8'h00,  16'h1010, 16'h1010, 0, 1));
        tbl.push_back(mk(0,0,1,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h1110, 16'h1110, 1, 0));
`else
        tbl.push_back(mk(0,0,0,1,8'h20,    0,16'h0000,  0,2'b00, 8'h00,  16'h1110, 16'h1110, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h1110, 16'h1110, 1, 0));
`endif
        tbl.push_back(mk(0,1,1,0,8'h00,    0,16'h0000,  0,2'b00, 8'h00,  16'h1110, 16'h1110, 1, 0));
        tbl.push_back(mk(0,0,1,0,8'h00,    1,16'h0000,  1,2'b00, 8'h00,  16'h1110, 16'hFFFA, 0, 1));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'hAD,  16'h11AD, 16'hFFFB, 0, 1));
        tbl.push_back(mk(0,1,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h55,  16'h11AD, 16'hFFFB, 0, 1));
        tbl.push_back(mk(0,1,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'h66,  16'h11AD, 16'hFFFB, 0, 1));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  0,2'b00, 8'hDE,  16'hDEAD, 16'hDEAD, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  1,2'b11, 8'h00,  16'hDEAD, 16'hFFFE, 0, 1));
        tbl.push_back(mk(0,0,1,0,8'h00,    1,16'h4444,  1,2'b00, 8'h00,  16'hDE00, 16'hFFFF, 0, 1));
        tbl.push_back(mk(0,0,1,1,8'h10,    1,16'h4444,  0,2'b00, 8'h80,  16'h8000, 16'h8000, 1, 0));
        tbl.push_back(mk(0,0,1,1,8'h05,    1,16'h2000,  0,2'b00, 8'h00,  16'h2000, 16'h2000, 1, 0));
        tbl.push_back(mk(0,0,1,1,8'h05,    0,16'h0000,  0,2'b00, 8'h00,  16'h2005, 16'h2005, 1, 0));
        tbl.push_back(mk(0,1,0,0,8'h00,    0,16'h0000,  1,2'b01, 8'h00,  16'h2005, 16'h2005, 1, 0));
        tbl.push_back(mk(0,0,0,0,8'h00,    0,16'h0000,  1,2'b01, 8'h00,  16'h2005, 16'hFFFC, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            stepAndCheck(tbl[i], $sformatf("row%0d", i));
        end

        // Reset in the middle of a stalled VEC_HI must override n_ready and restart the vector fetch
        stepAndCheck(mk(0,0,0,0,8'h00,0,16'h0,0,2'b00,8'h77, 16'h2077, 16'hFFFD, 0, 1), "midvec_lo");
        stepAndCheck(mk(1,1,0,0,8'h00,0,16'h0,0,2'b00,8'h99, 16'h0000, 16'hFFFC, 0, 1), "midvec_res");
        stepAndCheck(mk(0,0,0,0,8'h00,0,16'h0,0,2'b00,8'hCD, 16'h00CD, 16'hFFFD, 0, 1), "midvec_lo2");
        stepAndCheck(mk(0,0,0,0,8'h00,0,16'h0,0,2'b00,8'hAB, 16'hABCD, 16'hABCD, 1, 0), "midvec_run");

`ifdef PC_SEQ_PAGE_CROSS_EN
        stepAndCheck(mk(0,0,0,0,8'h00,1,16'h10F0,0,2'b00,8'h00, 16'h10F0, 16'h10F0, 1, 0), "brfix_jmp");
        stepAndCheck(mk(0,0,0,1,8'h20,0,16'h0000,0,2'b00,8'h00, 16'h1010, 16'h1010, 0, 1), "brfix_br");
        stepAndCheck(mk(1,0,0,0,8'h00,0,16'h0000,0,2'b00,8'h00, 16'h0000, 16'hFFFC, 0, 1), "brfix_res");
`else
        stepAndCheck(mk(0,0,0,0,8'h00,1,16'h10F0,0,2'b00,8'h00, 16'h10F0, 16'h10F0, 1, 0), "cross_jmp");
        stepAndCheck(mk(0,0,0,1,8'h20,0,16'h0000,0,2'b00,8'h00, 16'h1110, 16'h1110, 1, 0), "cross_br");
        stepAndCheck(mk(1,0,0,0,8'h00,0,16'h0000,0,2'b00,8'h00, 16'h0000, 16'hFFFC, 0, 1), "cross_res");
`endif
        stepAndCheck(mk(0,0,0,0,8'h00,0,16'h0,0,2'b00,8'h00, 16'h0000, 16'hFFFD, 0, 1), "post_res_lo");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port RES, input, 1, synchronous active-high reset.
REQ-003 SHALL have port n_ready, input, 1, stall: when 1, all state frozen.
REQ-004 SHALL have port inc_req, input, 1, increment PC by 1.
REQ-005 SHALL have port br_req, input, 1, take relative branch.
REQ-006 SHALL have port br_off, input, 8, signed two's-complement branch offset.
REQ-007 SHALL have port jmp_req, input, 1, load PC from jmp_addr.
REQ-008 SHALL have port jmp_addr, input, 16, absolute jump target.
REQ-009 SHALL have port vec_req, input, 1, start interrupt vector fetch.
REQ-010 SHALL have port vec_sel, input, 2, vector: 00 NMI FFFA, 01 RESET FFFC, 10 IRQ/BRK FFFE, 11 treated as 10.
REQ-011 SHALL have port data_in, input, 8, data bus byte during vector fetch.
REQ-012 SHALL have port PC, output, 16, program counter register.
REQ-013 SHALL have port addr, output, 16, address bus; combinational from state, PC and vector base.
REQ-014 SHALL have port fetch, output, 1, high in RUN state (addr = PC).
REQ-015 SHALL have port busy, output, 1, high in any state other than RUN; requests ignored while high.

Function
REQ-016 SHALL implement states RUN, BR_FIX, VEC_LO, VEC_HI.
REQ-017 In RUN with n_ready=0, SHALL serve exactly one request per cycle, priority vec_req > jmp_req > br_req > inc_req; lower-priority requests that cycle are dropped.
REQ-018 vec_req SHALL latch vector base from vec_sel, leave PC unchanged, enter VEC_LO next cycle.
REQ-019 jmp_req SHALL set PC=jmp_addr next cycle, stay in RUN.
REQ-020 br_req SHALL compute sum = PC + sign-extended br_off, modulo 2^16.
REQ-021 inc_req SHALL set PC=PC+1; FFFF wraps to 0000.
REQ-022 No request: PC and state hold.
REQ-023 VEC_LO: addr=base; PC[7:0]<=data_in; next VEC_HI.
REQ-024 VEC_HI: addr=base+1; PC[15:8]<=data_in; next RUN.
REQ-025 BR_FIX: PC[15:8]<=latched sum[15:8]; next RUN.
REQ-026 n_ready=1 SHALL freeze PC, state, latched base and latched sum in every state; addr, fetch, busy remain stable.
REQ-027 Vector base+1 SHALL not carry beyond 16 bits (FFFF+1 not reachable with legal bases).

Reset
REQ-028 RES=1 at a clock edge SHALL force PC=0000, base=FFFC, state=VEC_LO, overriding n_ready and all requests, from any state including mid-branch or mid-vector.
REQ-029 Outputs during/after reset before next edge: PC=0000, addr=FFFC, fetch=0, busy=1; sequence then proceeds VEC_LO, VEC_HI, RUN.

Configuration
REQ-030 Macro PC_SEQ_PAGE_CROSS_EN SHALL select branch page-cross behaviour.
REQ-031 With PC_SEQ_PAGE_CROSS_EN defined: if sum[15:8] != PC[15:8], branch cycle SHALL write PC={PC[15:8],sum[7:0]}, latch sum, enter BR_FIX (one extra cycle, busy=1); same page: PC=sum, stay RUN.
REQ-032 Without it: branch SHALL always write PC=sum in one cycle and BR_FIX SHALL be unreachable.

Verification
REQ-033 RES 1 cycle, n_ready=0, data_in 34 in VEC_LO then 12 in VEC_HI -> addr FFFC then FFFD, PC=1234, fetch=1 on third cycle.
REQ-034 PC=FFFE, inc_req 3 cycles -> PC FFFF, 0000, 0001.
REQ-035 PC=10F0, br_req, br_off=20, macro on -> PC 1010, busy=1, then PC 1110, RUN; macro off -> PC 1110 in one cycle.
REQ-036 PC=1234, br_off=FE (-2) -> PC 1232 in one cycle, no BR_FIX in either build.
REQ-037 RUN, vec_req+jmp_req+inc_req together, vec_sel=00 -> PC unchanged, addr FFFA then FFFB; n_ready=1 asserted during VEC_HI for 2 cycles -> addr holds FFFB, PC holds, completes after release.
REQ-038 RES asserted in BR_FIX -> state VEC_LO, PC=0000, addr=FFFC next cycle.
